// File: rtl/memi_arbiter_pkg.sv
// memi_pkg: shared definitions for the memi bus arbiter.
//   - memi_arb_state_t : sequencer state encoding (also exported for debug)
//   - clog2_min1/slv_w : index-width helpers that never return 0
//   - *_DFLT           : default memi widths shared with the debug port
package memi_pkg;

   localparam int MEMI_NR_SLAVES_DFLT   = 1;
   localparam int MEMI_ADDR_WIDTH_DFLT  = 5;
   localparam int MEMI_WDATA_WIDTH_DFLT = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } memi_arb_state_t;

   // Width of an index into n items, at least 1 bit so degenerate cases
   // (n = 1) still produce legal vectors.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int slv_w(input int nr_slaves);
      return clog2_min1(nr_slaves);
   endfunction

endpackage

// File: rtl/memi_arbiter_if.sv
// memi_arbiter_if: the shared memi bus.
//   memi_addr  : bus address
//   memi_sel   : one-hot slave select, the single-cycle transaction strobe
//   memi_wr_rd : 1 = write, 0 = read
//   memi_wdata : write data
//   memi_rdata : read data returned by the selected slave
// master modport = arbiter side, slave modport = memory/register side.
interface memi_arbiter_if #(
   parameter int NR_SLAVES   = 1,
   parameter int ADDR_WIDTH  = 5,
   parameter int WDATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]  memi_addr;
   logic [NR_SLAVES-1:0]   memi_sel;
   logic                   memi_wr_rd;
   logic [WDATA_WIDTH-1:0] memi_wdata;
   logic [WDATA_WIDTH-1:0] memi_rdata;

   modport master (
      output memi_addr, memi_sel, memi_wr_rd, memi_wdata,
      input  memi_rdata
   );

   modport slave (
      input  memi_addr, memi_sel, memi_wr_rd, memi_wdata,
      output memi_rdata
   );
endinterface

// File: rtl/memi_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant over NR_REQ request lines.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   en         : grant allowed this cycle
//   grant      : one-hot grant (all zero when en is low or no request)
//   grant_idx  : index of the selected requester (valid when grant != 0)
// The pointer names the requester with highest priority; it moves to
// winner+1 (with wrap) whenever a grant is issued.
module rr_arbiter
   import memi_pkg::*;
#(
   parameter  int NR_REQ = 2,
   localparam int IDX_W  = clog2_min1(NR_REQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NR_REQ-1:0] req,
   input  logic              en,
   output logic [NR_REQ-1:0] grant,
   output logic [IDX_W-1:0]  grant_idx
);

   logic [IDX_W-1:0] ptr;
   logic             found;

   // Search upward from the pointer, wrapping once.
   always_comb begin
      int k;
      k         = 0;
      found     = 1'b0;
      grant_idx = '0;
      grant     = '0;
      for (int i = 0; i < NR_REQ; i++) begin
         k = int'(ptr) + i;
         if (k >= NR_REQ) k = k - NR_REQ;
         if (!found && req[k]) begin
            found     = 1'b1;
            grant_idx = IDX_W'(k);
         end
      end
      if (en && found) grant[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (en && found) begin
         ptr <= (grant_idx == IDX_W'(NR_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/memi_arbiter.sv
// memi_arbiter: shares one memi bus between NR_REQ requesters.
//   memi_clk, memi_rst : clock, asynchronous active-low reset
//   req_valid/req_ready: per-requester request handshake
//   req_wr_rd/slave/addr/wdata : flattened request payloads
//   rsp_valid, rsp_rdata : one-cycle completion pulse and read data
//   memi               : memi bus (master side)
//   dbg_state          : current sequencer state
//
// Handshake: a requester raises req_valid with a stable payload and keeps
// both until it sees req_ready; the transfer happens on the clock edge
// where req_valid & req_ready are both 1. req_ready is only ever offered
// in IDLE, to at most one requester, and never while reset is asserted.
module memi_arbiter
   import memi_pkg::*;
#(
   parameter  int NR_REQ           = 2,
   parameter  int MEMI_NR_SLAVES   = MEMI_NR_SLAVES_DFLT,
   parameter  int MEMI_ADDR_WIDTH  = MEMI_ADDR_WIDTH_DFLT,
   parameter  int MEMI_WDATA_WIDTH = MEMI_WDATA_WIDTH_DFLT,
   parameter  int RD_LATENCY       = 1,
   localparam int SLV_W            = slv_w(MEMI_NR_SLAVES)
) (
   input  logic                               memi_clk,
   input  logic                               memi_rst,
   input  logic [NR_REQ-1:0]                  req_valid,
   output logic [NR_REQ-1:0]                  req_ready,
   input  logic [NR_REQ-1:0]                  req_wr_rd,
   input  logic [NR_REQ*SLV_W-1:0]            req_slave,
   input  logic [NR_REQ*MEMI_ADDR_WIDTH-1:0]  req_addr,
   input  logic [NR_REQ*MEMI_WDATA_WIDTH-1:0] req_wdata,
   output logic [NR_REQ-1:0]                  rsp_valid,
   output logic [MEMI_WDATA_WIDTH-1:0]        rsp_rdata,
   memi_arbiter_if.master                     memi,
   output memi_arb_state_t                    dbg_state
);

   localparam int IDX_W = clog2_min1(NR_REQ);
   localparam int CNT_W = clog2_min1(RD_LATENCY);

   memi_arb_state_t             state_q, state_d;
   logic [NR_REQ-1:0]           grant;
   logic [IDX_W-1:0]            grant_idx;
   logic                        arb_en, hs;
   logic [IDX_W-1:0]            win_q;
   logic                        wr_rd_q;
   logic [SLV_W-1:0]            slave_q;
   logic [MEMI_ADDR_WIDTH-1:0]  addr_q;
   logic [MEMI_WDATA_WIDTH-1:0] wdata_q;
   logic [MEMI_WDATA_WIDTH-1:0] rdata_q;
   logic [CNT_W-1:0]            cnt_q;
   logic                        cnt_last;
   logic [MEMI_NR_SLAVES-1:0]   sel_dec;
   logic                        slave_ok;

   // Gate with reset so no requester sees ready while reset is held.
   assign arb_en = (state_q == ST_IDLE) && memi_rst;

   rr_arbiter #(.NR_REQ(NR_REQ)) u_rr (
      .clk       (memi_clk),
      .rst_n     (memi_rst),
      .req       (req_valid),
      .en        (arb_en),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready = grant;
   assign hs        = |grant;
   assign cnt_last  = (cnt_q == CNT_W'(RD_LATENCY - 1));

   // Out-of-range slave indices decode to no select at all.
   always_comb begin
      sel_dec = '0;
      for (int s = 0; s < MEMI_NR_SLAVES; s++) begin
         sel_dec[s] = (slave_q == SLV_W'(s));
      end
   end
   assign slave_ok = |sel_dec;

   always_ff @(posedge memi_clk or negedge memi_rst) begin
      if (!memi_rst) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (hs) state_d = ST_ISSUE;
         ST_ISSUE: state_d = wr_rd_q ? ST_IDLE : ST_WAIT;
         ST_WAIT:  if (cnt_last) state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Payload registers double as the bus drivers, so the bus holds the
   // last transaction's values between transactions.
   always_ff @(posedge memi_clk or negedge memi_rst) begin
      if (!memi_rst) begin
         win_q   <= '0;
         wr_rd_q <= 1'b0;
         slave_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         if (hs) begin
            win_q   <= grant_idx;
            wr_rd_q <= req_wr_rd[grant_idx];
            slave_q <= req_slave[int'(grant_idx)*SLV_W +: SLV_W];
            addr_q  <= req_addr[int'(grant_idx)*MEMI_ADDR_WIDTH +: MEMI_ADDR_WIDTH];
            wdata_q <= req_wdata[int'(grant_idx)*MEMI_WDATA_WIDTH +: MEMI_WDATA_WIDTH];
         end
         if (state_q == ST_ISSUE) begin
            cnt_q <= '0;
         end else if (state_q == ST_WAIT && !cnt_last) begin
            cnt_q <= cnt_q + 1'b1;
         end
         // Last WAIT cycle is ISSUE+RD_LATENCY: slave data is valid here.
         if (state_q == ST_WAIT && cnt_last) begin
            rdata_q <= slave_ok ? memi.memi_rdata : '0;
         end
      end
   end

   assign memi.memi_sel   = (state_q == ST_ISSUE) ? sel_dec : '0;
   assign memi.memi_addr  = addr_q;
   assign memi.memi_wr_rd = wr_rd_q;
   assign memi.memi_wdata = wdata_q;

   // Writes complete in ISSUE itself; reads complete in RESP.
   always_comb begin
      rsp_valid = '0;
      if ((state_q == ST_ISSUE && wr_rd_q) || state_q == ST_RESP) begin
         rsp_valid[win_q] = 1'b1;
      end
   end

   assign rsp_rdata = rdata_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_memi_arbiter.sv
// tb_memi_arbiter: directed and randomized bench for memi_arbiter with
// two requesters, three slaves and a two-cycle read latency.
module tb_memi_arbiter;
   import memi_pkg::*;

   localparam int NR = 2;
   localparam int NS = 3;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int RL = 2;
   localparam int SW = 2;

   logic             clk;
   logic             rst_n;
   logic [NR-1:0]    req_valid, req_ready, req_wr_rd, rsp_valid;
   logic [NR*SW-1:0] req_slave;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [DW-1:0]    rsp_rdata;
   memi_arb_state_t  dbg_state;
   logic             mem_init;

   memi_arbiter_if #(.NR_SLAVES(NS), .ADDR_WIDTH(AW), .WDATA_WIDTH(DW)) bus ();

   memi_arbiter #(
      .NR_REQ(NR), .MEMI_NR_SLAVES(NS), .MEMI_ADDR_WIDTH(AW),
      .MEMI_WDATA_WIDTH(DW), .RD_LATENCY(RL)
   ) dut (
      .memi_clk  (clk),
      .memi_rst  (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr_rd (req_wr_rd),
      .req_slave (req_slave),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .memi      (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- counters / check ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] init_word(input int s, input int a);
      return 32'h1234_5678 + 32'(s << 8) + 32'(a);
   endfunction

   function automatic logic [1:0] sel_idx(input logic [NS-1:0] sel);
      logic [1:0] r;
      r = 2'd0;
      for (int s = 0; s < NS; s++) if (sel[s]) r = 2'(s);
      return r;
   endfunction

   // ---------------- slave memory with RL-cycle read pipe ----------------
   logic [31:0] mem [NS][32];
   logic        st1_v, st2_v;
   logic [1:0]  st1_s, st2_s;
   logic [4:0]  st1_a, st2_a;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int s = 0; s < NS; s++)
            for (int a = 0; a < 32; a++) mem[s][a] <= init_word(s, a);
      end else if (bus.memi_sel != '0 && bus.memi_wr_rd) begin
         mem[sel_idx(bus.memi_sel)][bus.memi_addr] <= bus.memi_wdata;
      end
      st1_v <= (bus.memi_sel != '0) && !bus.memi_wr_rd;
      st1_s <= sel_idx(bus.memi_sel);
      st1_a <= bus.memi_addr;
      st2_v <= st1_v;
      st2_s <= st1_s;
      st2_a <= st1_a;
   end

   assign bus.memi_rdata = st2_v ? mem[st2_s][st2_a] : 32'hBADC_0DE0;

   // ---------------- scoreboard ----------------
   // entry = {handshake cycle[15:0], wr, idx, expected rdata}
   logic [49:0] exp_q[$];
   logic [31:0] model [NS][32];
   int          cyc = 0;
   logic        prev_sel = 1'b0;

   always @(negedge clk) begin : monitor
      logic [49:0] e;
      int          i;
      logic [1:0]  s;
      logic [4:0]  a;
      logic [31:0] d;
      cyc = cyc + 1;
      if (mem_init) begin
         for (int ss = 0; ss < NS; ss++)
            for (int aa = 0; aa < 32; aa++) model[ss][aa] = init_word(ss, aa);
      end
      if (!rst_n) begin
         exp_q.delete();
         prev_sel = 1'b0;
      end else begin
         if (bus.memi_sel != '0) check("sel_gap", 64'(prev_sel), 64'd0);
         prev_sel = (bus.memi_sel != '0);
         if ((req_valid & req_ready) != '0) begin
            i = req_ready[1] ? 1 : 0;
            s = req_slave[i*SW +: SW];
            a = req_addr[i*AW +: AW];
            d = req_wdata[i*DW +: DW];
            if (req_wr_rd[i]) begin
               if (s < 2'd3) model[s][a] = d;
               exp_q.push_back({cyc[15:0], 1'b1, i[0], 32'h0});
            end else begin
               exp_q.push_back({cyc[15:0], 1'b0, i[0], (s < 2'd3) ? model[s][a] : 32'h0});
            end
         end
         if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
               check("rsp_spurious", 64'(rsp_valid), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_who", 64'(rsp_valid), e[32] ? 64'd2 : 64'd1);
               check("rsp_lat", 64'(cyc[15:0] - e[49:34]), e[33] ? 64'd1 : 64'(RL + 2));
               if (!e[33]) check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load(input int i, input logic wr, input logic [1:0] s,
                       input logic [4:0] a, input logic [31:0] d);
      req_wr_rd[i]         = wr;
      req_slave[i*SW +: SW] = s;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
      req_valid[i]          = 1'b1;
   endtask

   // Returns just after the handshake edge with the request dropped.
   task automatic wait_hs(input int i);
      logic got;
      got = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (req_ready[i]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("hs_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
   endtask

   // Both requesters stay valid; grants must alternate starting at req0.
   task automatic grant_seq(input int count);
      int n, last_t, g;
      n = 0;
      last_t = 0;
      for (int t = 0; t < 100 && n < count; t++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            g = req_ready[1] ? 1 : 0;
            check("rr_grant", 64'(g), 64'(n % 2));
            if (n > 0) check("rr_gap", 64'(t - last_t), 64'd2);
            last_t = t;
            n++;
            @(posedge clk);
            #1;
            req_wdata[g*DW +: DW] = $urandom;
            if (n == count) req_valid = '0;
         end
      end
      if (n != count) check("rr_timeout", 64'(n), 64'(count));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      logic any;
      logic [NR-1:0] hs;
      int issued;

      rst_n = 1'b0;
      mem_init = 1'b1;
      req_valid = '0;
      req_wr_rd = '0;
      req_slave = '0;
      req_addr = '0;
      req_wdata = '0;

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sel", 64'(bus.memi_sel), 64'd0);
      check("rst_addr", 64'(bus.memi_addr), 64'd0);
      check("rst_wr_rd", 64'(bus.memi_wr_rd), 64'd0);
      check("rst_wdata", 64'(bus.memi_wdata), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      req_valid = 2'b11;
      #1;
      check("rst_ready", 64'(req_ready), 64'd0);
      req_valid = '0;
      @(posedge clk);
      #1;
      mem_init = 1'b0;
      rst_n = 1'b1;
      idle(1);

      // single write from req0
      load(0, 1'b1, 2'd0, 5'h0A, 32'hDEAD_BEEF);
      wait_hs(0);
      @(negedge clk);
      check("wr_sel", 64'(bus.memi_sel), 64'd1);
      check("wr_wr_rd", 64'(bus.memi_wr_rd), 64'd1);
      check("wr_addr", 64'(bus.memi_addr), 64'h0A);
      check("wr_wdata", 64'(bus.memi_wdata), 64'hDEAD_BEEF);
      check("wr_rsp", 64'(rsp_valid), 64'd1);
      @(negedge clk);
      check("wr_sel_after", 64'(bus.memi_sel), 64'd0);
      check("wr_addr_hold", 64'(bus.memi_addr), 64'h0A);
      idle(1);

      // read, slave returns 12345678 at slave 0 address 0
      load(0, 1'b0, 2'd0, 5'h00, 32'h0);
      wait_hs(0);
      n = 1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (rsp_valid[0]) break;
         n++;
      end
      check("rd_lat", 64'(n), 64'(RL + 2));
      check("rd_data", 64'(rsp_rdata), 64'h1234_5678);
      idle(1);

      // single write from req1 so req0 is next in line
      load(1, 1'b1, 2'd1, 5'h03, 32'hCAFE_0001);
      wait_hs(1);
      idle(3);

      // six back-to-back writes, both requesters holding valid
      load(0, 1'b1, 2'd2, 5'h04, $urandom);
      load(1, 1'b1, 2'd2, 5'h05, $urandom);
      grant_seq(6);
      idle(3);

      // out-of-range slave read: no strobe, zero data, normal timing
      load(1, 1'b0, 2'd3, 5'h07, 32'h0);
      wait_hs(1);
      n = 1;
      any = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         any = any | (bus.memi_sel != '0);
         if (rsp_valid[1]) break;
         n++;
      end
      check("oor_sel", 64'(any), 64'd0);
      check("oor_lat", 64'(n), 64'(RL + 2));
      check("oor_rdata", 64'(rsp_rdata), 64'd0);
      idle(1);

      // reset during WAIT of a req0 read (pointer then favours req1)
      load(0, 1'b0, 2'd1, 5'h02, 32'h0);
      wait_hs(0);
      @(negedge clk);
      @(negedge clk);
      check("mid_state", 64'(dbg_state), 64'(ST_WAIT));
      rst_n = 1'b0;
      #1;
      check("mid_state_rst", 64'(dbg_state), 64'(ST_IDLE));
      check("mid_sel", 64'(bus.memi_sel), 64'd0);
      check("mid_addr", 64'(bus.memi_addr), 64'd0);
      check("mid_wdata", 64'(bus.memi_wdata), 64'd0);
      check("mid_rsp", 64'(rsp_valid), 64'd0);
      check("mid_rdata", 64'(rsp_rdata), 64'd0);
      load(0, 1'b1, 2'd0, 5'h01, $urandom);
      load(1, 1'b1, 2'd0, 5'h02, $urandom);
      #1;
      check("mid_ready", 64'(req_ready), 64'd0);
      any = 1'b0;
      repeat (3) begin
         @(negedge clk);
         any = any | (rsp_valid != '0);
      end
      check("mid_no_rsp", 64'(any), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      grant_seq(2);
      idle(4);

      // randomized back-to-back traffic
      issued = 0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++) begin
            if (hs[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && issued < 40 && $urandom_range(0, 3) != 0) begin
               load(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), $urandom);
               issued++;
            end
         end
         if (issued >= 40 && req_valid == '0) break;
      end
      check("rand_done", 64'(req_valid), 64'd0);

      for (int t = 0; t < 100; t++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      idle(3);
      check("drain", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
